drop_sequencer: RTL and testbench

- Sequential front end for the baggage-drop datapath.
- On a start request it latches the four height sensors and derives a validated height. It then runs an iterative fixed-point square root, halves it to obtain t_act, and compares t_act against t_lim to decide drop_activated.
- Replaces the purely combinational sensor-to-sqrt path. t_act is exported so display_and_drop keeps driving the seven-segment outputs.

---
 rtl/drop_pkg.sv | 34 +++
 rtl/drop_sequencer_sqrt_iter.sv | 80 ++++++++
 rtl/drop_sequencer.sv | 141 ++++++++++++++
 tb/tb_drop_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared types, widths and the sensor-validation function for the baggage-drop sequencer.
package drop_pkg;

    localparam int T_W = 16;
    localparam int H_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SQRT,
        COMPARE,
        DONE
    } state_t;

    // A zero reading marks a faulty sensor; its whole pair is then discarded.
    function automatic logic [H_W-1:0] calc_height(
        input logic [H_W-1:0] s1,
        input logic [H_W-1:0] s2,
        input logic [H_W-1:0] s3,
        input logic [H_W-1:0] s4
    );
        logic [H_W+1:0] sum;
        sum = '0;
        if (s1 == '0 || s3 == '0) begin
            sum = ({2'b00, s2} + {2'b00, s4}) >> 1;
        end else if (s2 == '0 || s4 == '0) begin
            sum = ({2'b00, s1} + {2'b00, s3}) >> 1;
        end else begin
            sum = ({2'b00, s1} + {2'b00, s2} + {2'b00, s3} + {2'b00, s4}) >> 2;
        end
        return H_W'(sum);
    endfunction

endpackage

// File: rtl/drop_sequencer_sqrt_iter.sv
// Digit-by-digit integer square root, one root bit per cycle, MSB first.
// The first digit is resolved on the start cycle, so done follows N-1 cycles later.
module sqrt_iter
    import drop_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2*(4+FRAC_BITS)-1:0]    radicand,
    output logic                          done,
    output logic [T_W-1:0]                root
);

    localparam int N     = 4 + FRAC_BITS;
    localparam int RAD_W = 2 * N;
    localparam int REM_W = N + 2;
    localparam int EXT_W = N + 4;
    localparam int CNT_W = $clog2(N + 1);

    logic [RAD_W-1:0] r_rad;
    logic [REM_W-1:0] r_rem;
    logic [N-1:0]     r_root;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [RAD_W-1:0] w_rad_in;
    logic [REM_W-1:0] w_rem_in;
    logic [N-1:0]     w_root_in;
    logic [EXT_W-1:0] w_rem_sh;
    logic [EXT_W-1:0] w_trial;
    logic [EXT_W-1:0] w_rem_step;
    logic [N-1:0]     w_root_step;
    logic             w_fits;

    always_comb begin
        w_rad_in    = start ? radicand : r_rad;
        w_rem_in    = start ? '0 : r_rem;
        w_root_in   = start ? '0 : r_root;
        w_rem_sh    = (EXT_W'(w_rem_in) << 2) | EXT_W'(w_rad_in[RAD_W-1 -: 2]);
        w_trial     = (EXT_W'(w_root_in) << 2) | EXT_W'(1);
        w_fits      = (w_rem_sh >= w_trial);
        w_rem_step  = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
        w_root_step = (w_root_in << 1) | N'(w_fits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_busy) begin
                r_rad  <= w_rad_in << 2;
                r_rem  <= REM_W'(w_rem_step);
                r_root <= w_root_step;
                if (start) begin
                    r_cnt  <= CNT_W'(1);
                    r_busy <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign done = r_done;
    assign root = T_W'(r_root);

endmodule

// File: rtl/drop_sequencer.sv
// Sequential baggage-drop front end: capture sensors, iterative sqrt, halve, compare to t_lim.
// Optional fault detection output enabled by defining DROP_SEQ_FAULT_DET_EN.
module drop_sequencer
    import drop_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [H_W-1:0]  sensor1,
    input  logic [H_W-1:0]  sensor2,
    input  logic [H_W-1:0]  sensor3,
    input  logic [H_W-1:0]  sensor4,
    input  logic [T_W-1:0]  t_lim,
    input  logic            drop_en,
    output logic            busy,
    output logic            done,
    output logic [T_W-1:0]  t_act,
    output logic            drop_activated
`ifdef DROP_SEQ_FAULT_DET_EN
    ,
    output logic            fault
`endif
);

    localparam int N     = 4 + FRAC_BITS;
    localparam int RAD_W = 2 * N;

    state_t         r_state;
    state_t         w_state_next;
    logic [H_W-1:0] r_sensor [4];
    logic [H_W-1:0] w_sensor_in [4];
    logic [T_W-1:0] r_t_act;
    logic           r_drop;
    logic [H_W-1:0] w_height;
    logic [RAD_W-1:0] w_radicand;
    logic [T_W-1:0] w_root;
    logic [T_W-1:0] w_t_next;
    logic           w_sqrt_done;
    logic           w_sqrt_start;
    logic           w_drop_allow;

    assign w_sensor_in[0] = sensor1;
    assign w_sensor_in[1] = sensor2;
    assign w_sensor_in[2] = sensor3;
    assign w_sensor_in[3] = sensor4;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sensor_latch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sensor[gi] <= '0;
                end else if (r_state == IDLE && start) begin
                    r_sensor[gi] <= w_sensor_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CAPTURE;
            CAPTURE: w_state_next = SQRT;
            SQRT:    if (w_sqrt_done) w_state_next = COMPARE;
            COMPARE: w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The root engine loads straight from the combinational height during CAPTURE.
    assign w_height     = calc_height(r_sensor[0], r_sensor[1], r_sensor[2], r_sensor[3]);
    assign w_radicand   = RAD_W'(w_height) << (2 * FRAC_BITS);
    assign w_sqrt_start = (r_state == CAPTURE);

    sqrt_iter #(
        .FRAC_BITS (FRAC_BITS)
    ) u_sqrt_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_sqrt_start),
        .radicand (w_radicand),
        .done     (w_sqrt_done),
        .root     (w_root)
    );

    assign w_t_next = w_root >> 1;

`ifdef DROP_SEQ_FAULT_DET_EN
    logic r_fault;
    logic w_fault;

    assign w_fault = ((r_sensor[0] == '0 || r_sensor[2] == '0) &&
                      (r_sensor[1] == '0 || r_sensor[3] == '0)) || (w_height == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_fault <= w_fault;
        end
    end

    assign w_drop_allow = !r_fault;
    assign fault        = r_fault;
`else
    assign w_drop_allow = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_act <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (r_state == CAPTURE) begin
                r_drop <= 1'b0;
            end
            if (r_state == COMPARE) begin
                r_t_act <= w_t_next;
                r_drop  <= drop_en && (w_t_next <= t_lim) && w_drop_allow;
            end
        end
    end

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign t_act          = r_t_act;
    assign drop_activated = r_drop;

endmodule

// File: tb/tb_drop_sequencer.sv
// Randomized self-checking bench for drop_sequencer against an arithmetic reference model.
module tb_drop_sequencer;

    localparam int F   = 8;
    localparam int LAT = 6 + F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s1 = '0, s2 = '0, s3 = '0, s4 = '0;
    logic [15:0] t_lim = '0;
    logic        drop_en = 1'b0;
    logic        busy, done, drop_activated;
    logic [15:0] t_act;
`ifdef DROP_SEQ_FAULT_DET_EN
    logic        fault;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_op    = 0;

    drop_sequencer #(.FRAC_BITS(F)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sensor1        (s1),
        .sensor2        (s2),
        .sensor3        (s3),
        .sensor4        (s4),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .busy           (busy),
        .done           (done),
        .t_act          (t_act),
        .drop_activated (drop_activated)
`ifdef DROP_SEQ_FAULT_DET_EN
        ,
        .fault          (fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_height(int a, int b, int c, int d);
        if (a == 0 || c == 0) return (b + d) / 2;
        if (b == 0 || d == 0) return (a + c) / 2;
        return (a + b + c + d) / 4;
    endfunction

    function automatic int model_tact(int a, int b, int c, int d);
        longint v;
        longint r;
        v = longint'(model_height(a, b, c, d)) * (longint'(1) << (2 * F));
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return int'(r / 2);
    endfunction

    function automatic bit model_fault(int a, int b, int c, int d);
        return ((a == 0 || c == 0) && (b == 0 || d == 0)) || model_height(a, b, c, d) == 0;
    endfunction

    // mode 0: plain run; 1: re-start and sensor toggle during SQRT;
    // 2: drop_en holds den only in COMPARE; 3: reset in the middle of SQRT
    task automatic run_op(input int a, input int b, input int c, input int d,
                          input logic [15:0] tl, input bit den, input int mode, input string tag);
        int  lat;
        int  exp_tact;
        bit  exp_drop;
        bit  exp_fault;
        int  extra_done;
        exp_tact  = model_tact(a, b, c, d);
        exp_fault = 1'b0;
`ifdef DROP_SEQ_FAULT_DET_EN
        exp_fault = model_fault(a, b, c, d);
`endif
        exp_drop  = den && (exp_tact <= int'(tl)) && !exp_fault;
        n_op++;

        @(negedge clk);
        s1 = 8'(a); s2 = 8'(b); s3 = 8'(c); s4 = 8'(d);
        t_lim   = tl;
        drop_en = (mode == 2) ? !den : den;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) check({tag, "_drop_clr"}, 32'(drop_activated), 32'd0);
            if (mode == 1 && lat == 5) begin
                start = 1'b1;
                s1 = 8'($urandom); s2 = 8'($urandom); s3 = 8'($urandom); s4 = 8'($urandom);
            end
            if (mode == 1 && lat == 6) start = 1'b0;
            if (mode == 2 && lat == LAT - 1) drop_en = den;
            if (mode == 2 && lat == LAT) drop_en = !den;
            if (mode == 3 && lat == 6) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_tact"}, 32'(t_act), 32'd0);
                check({tag, "_rst_drop"}, 32'(drop_activated), 32'd0);
`ifdef DROP_SEQ_FAULT_DET_EN
                check({tag, "_rst_fault"}, 32'(fault), 32'd0);
`endif
                @(negedge clk);
                rst_n = 1'b1;
                $display("op %0d %s: reset asserted at cycle %0d, outputs cleared", n_op, tag, lat);
                return;
            end
            if (done) break;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_tact"}, 32'(t_act), 32'(exp_tact));
        check({tag, "_drop"}, 32'(drop_activated), 32'(exp_drop));
`ifdef DROP_SEQ_FAULT_DET_EN
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (mode == 1) begin
            extra_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) extra_done++;
            end
            check({tag, "_no_requeue"}, 32'(extra_done), 32'd0);
            check({tag, "_tact_hold"}, 32'(t_act), 32'(exp_tact));
        end
        $display("op %0d %s: s=%0d,%0d,%0d,%0d t_lim=%04h den=%0b -> t_act=%04h drop=%0b lat=%0d",
                 n_op, tag, a, b, c, d, tl, den, t_act, drop_activated, lat);
    endtask

    initial begin
        int a, b, c, d, tact;
        logic [15:0] tl;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tact", 32'(t_act), 32'd0);
        check("reset_drop", 32'(drop_activated), 32'd0);
`ifdef DROP_SEQ_FAULT_DET_EN
        check("reset_fault", 32'(fault), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32, 32, 32, 32, 16'h0300, 1'b1, 0, "h32_lim300");
        run_op(32, 32, 32, 32, 16'h02D3, 1'b1, 0, "h32_lim2d3");
        run_op(4, 4, 4, 4, 16'h0100, 1'b1, 0, "h4_equal");
        run_op(0, 50, 10, 50, 16'hFFFF, 1'b1, 0, "pair_sub");
        run_op(10, 0, 30, 7, 16'hFFFF, 1'b1, 0, "pair_sub2");
        run_op(32, 32, 32, 32, 16'h0300, 1'b1, 1, "disturb");
        run_op(32, 32, 32, 32, 16'hFFFF, 1'b0, 2, "den_low_cmp");
        run_op(32, 32, 32, 32, 16'hFFFF, 1'b1, 2, "den_high_cmp");
        run_op(200, 200, 200, 200, 16'hFFFF, 1'b1, 3, "mid_reset");
        run_op(255, 255, 255, 255, 16'h0000, 1'b1, 0, "after_reset");
        run_op(0, 0, 0, 0, 16'h0000, 1'b1, 0, "height0");
        run_op(0, 0, 5, 7, 16'hFFFF, 1'b1, 0, "both_pairs_bad");
        run_op(9, 16, 25, 36, 16'hFFFF, 1'b1, 0, "valid_after");

        for (int k = 0; k < 24; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            tact = model_tact(a, b, c, d);
            if ($urandom_range(0, 1) == 0) tl = 16'($urandom);
            else tl = 16'(tact + int'($urandom_range(0, 2)) - 1);
            run_op(a, b, c, d, tl, 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
